// File: rtl/mult_seq.sv
// Iterative W x W -> 2W multiplier, D multiplier bits per cycle.
// Signed or unsigned per operation; level-held start/done handshake.
module mult_seq #(
  parameter int W = 17,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_op,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  localparam int N  = (W + D - 1) / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = N * D;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   am;
  logic [W-1:0]   bm;
  logic           sign;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [PW-1:0]  bpad;
  logic [D-1:0]   digit;
  logic [2*W-1:0] part;
  logic [2*W-1:0] acc_next;
  int             sh;

  assign a_mag = (signed_op & A[W-1]) ? -A : A;
  assign b_mag = (signed_op & B[W-1]) ? -B : B;

  // Multiplier is zero-padded up to N*D bits so the last digit is clean.
  always_comb begin
    bpad = '0;
    bpad[W-1:0] = bm;
    sh = int'(cnt) * D;
    digit = bpad[sh +: D];
    part = ({{W{1'b0}}, am} *
            {{(2*W-D){1'b0}}, digit}) << sh;
    acc_next = acc + part;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      am    <= '0;
      bm    <= '0;
      sign  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            am    <= a_mag;
            bm    <= b_mag;
            sign  <= signed_op & (A[W-1] ^ B[W-1]);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Abort wins over completion on the same edge.
          if (!start) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == CW'(N - 1)) begin
            P     <= sign ? -acc_next : acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed handshake tests on W=17/D=4 plus a
// random sweep over D=4, D=1, D=17 and W=8/D=3 against a reference.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [16:0] a17 = '0;
  logic [16:0] b17 = '0;

  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic [33:0] p0, p1, p2;
  logic [15:0] p3;

  int vecs = 0;
  int errs = 0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [33:0] q2[$];
  logic [33:0] q3[$];

  localparam int N0 = 5;

  always #5 clk = ~clk;

  mult_seq #(.W(17), .D(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_op(signed_op), .A(a17), .B(b17),
    .busy(busy0), .done(done0), .P(p0));

  mult_seq #(.W(17), .D(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_op(signed_op), .A(a17), .B(b17),
    .busy(busy1), .done(done1), .P(p1));

  mult_seq #(.W(17), .D(17)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_op(signed_op), .A(a17), .B(b17),
    .busy(busy2), .done(done2), .P(p2));

  mult_seq #(.W(8), .D(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_op(signed_op), .A(a17[7:0]), .B(b17[7:0]),
    .busy(busy3), .done(done3), .P(p3));

  function automatic logic [33:0] ref17(
    input logic [16:0] a, input logic [16:0] b, input logic s);
    longint x, y, r;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    r = x * y;
    return r[33:0];
  endfunction

  function automatic logic [15:0] ref8(
    input logic [7:0] a, input logic [7:0] b, input logic s);
    longint x, y, r;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    r = x * y;
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int c, output int bc);
    c = 0;
    bc = 0;
    while (!done0 && c < 40) begin
      tick();
      c++;
      if (busy0) bc++;
    end
  endtask

  task automatic do_op(input logic [16:0] a, input logic [16:0] b,
                       input logic s, output int c, output int bc);
    a17 = a;
    b17 = b;
    signed_op = s;
    start = 1'b1;
    wait_done(c, bc);
  endtask

  task automatic release_start();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #3;
    vecs++;
    if (p0 !== 34'h0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      errs++;
      $display("FAIL reset: P=%h done=%b busy=%b want 0/0/0",
               p0, done0, busy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_max();
    int c, bc;
    logic [33:0] e;
    q0.push_back(34'h3FFFC0001);
    do_op(17'h1FFFF, 17'h1FFFF, 1'b0, c, bc);
    e = q0.pop_front();
    vecs++;
    if (done0 !== 1'b1) begin
      errs++;
      $display("FAIL umax_timeout: done=%b want 1", done0);
    end
    vecs++;
    if (c - 1 != N0) begin
      errs++;
      $display("FAIL umax_latency: got %0d want %0d", c - 1, N0);
    end
    vecs++;
    if (bc != N0) begin
      errs++;
      $display("FAIL umax_busy: got %0d cycles want %0d", bc, N0);
    end
    vecs++;
    if (p0 !== e) begin
      errs++;
      $display("FAIL umax_P: got %h want %h", p0, e);
    end
    release_start();
    vecs++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errs++;
      $display("FAIL umax_release: done=%b busy=%b want 0/0",
               done0, busy0);
    end
  endtask

  task automatic test_signed();
    logic [16:0] ta[3] = '{17'h1FFFF, 17'h10000, 17'h10000};
    logic [16:0] tb[3] = '{17'h00003, 17'h10000, 17'h00001};
    logic [33:0] tp[3] = '{34'h3FFFFFFFD, 34'h100000000,
                           34'h3FFFF0000};
    int c, bc;
    logic [33:0] e;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(tp[i]);
      do_op(ta[i], tb[i], 1'b1, c, bc);
      e = q0.pop_front();
      vecs++;
      if (p0 !== e || done0 !== 1'b1) begin
        errs++;
        $display("FAIL signed_%0d: got P=%h done=%b want %h/1",
                 i, p0, done0, e);
      end
      vecs++;
      if (c - 1 != N0) begin
        errs++;
        $display("FAIL signed_lat_%0d: got %0d want %0d", i, c - 1, N0);
      end
      release_start();
    end
  endtask

  task automatic test_abort();
    int c, bc;
    logic [33:0] e;
    logic bad;
    q0.push_back(34'd6);
    do_op(17'd2, 17'd3, 1'b0, c, bc);
    e = q0.pop_front();
    vecs++;
    if (p0 !== e) begin
      errs++;
      $display("FAIL abort_pre: got %h want %h", p0, e);
    end
    release_start();
    a17 = 17'd7;
    b17 = 17'd9;
    start = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done0 !== 1'b0 || busy0 !== 1'b1) bad = 1'b1;
    end
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL abort_run: done/busy wrong during run, want 0/1");
    end
    start = 1'b0;
    tick();
    vecs++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || p0 !== 34'd6) begin
      errs++;
      $display("FAIL abort_edge: busy=%b done=%b P=%h want 0/0/6",
               busy0, done0, p0);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done0 !== 1'b0 || p0 !== 34'd6) bad = 1'b1;
    end
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL abort_hold: done=%b P=%h want 0/6", done0, p0);
    end
    q0.push_back(34'd63);
    do_op(17'd7, 17'd9, 1'b0, c, bc);
    e = q0.pop_front();
    vecs++;
    if (p0 !== e || c - 1 != N0) begin
      errs++;
      $display("FAIL abort_rerun: got P=%h lat=%0d want %h lat=%0d",
               p0, c - 1, e, N0);
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    int c, bc;
    logic [33:0] e;
    a17 = 17'd5;
    b17 = 17'd6;
    signed_op = 1'b0;
    start = 1'b1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    vecs++;
    if (p0 !== 34'h0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: P=%h done=%b busy=%b want 0/0/0",
               p0, done0, busy0);
    end
    #2;
    rst_n = 1'b1;
    q0.push_back(34'd30);
    wait_done(c, bc);
    e = q0.pop_front();
    vecs++;
    if (p0 !== e || c - 1 != N0 || bc != N0) begin
      errs++;
      $display("FAIL reset_restart: P=%h lat=%0d busy=%0d want %h/%0d/%0d",
               p0, c - 1, bc, e, N0, N0);
    end
    release_start();
  endtask

  task automatic test_handshake();
    int c, bc;
    logic [33:0] e;
    q0.push_back(34'd12);
    do_op(17'd3, 17'd4, 1'b0, c, bc);
    e = q0.pop_front();
    vecs++;
    if (p0 !== e) begin
      errs++;
      $display("FAIL hs_first: got %h want %h", p0, e);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (p0 !== 34'd12 || done0 !== 1'b1 || busy0 !== 1'b0) begin
        errs++;
        $display("FAIL hs_hold_%0d: P=%h done=%b busy=%b want 00c/1/0",
                 i, p0, done0, busy0);
      end
    end
    release_start();
    vecs++;
    if (done0 !== 1'b0 || p0 !== 34'd12) begin
      errs++;
      $display("FAIL hs_drop: done=%b P=%h want 0/00c", done0, p0);
    end
    q0.push_back(34'd25);
    do_op(17'd5, 17'd5, 1'b0, c, bc);
    e = q0.pop_front();
    vecs++;
    if (p0 !== e || c - 1 != N0) begin
      errs++;
      $display("FAIL hs_second: P=%h lat=%0d want %h/%0d",
               p0, c - 1, e, N0);
    end
    release_start();
  endtask

  task automatic test_sweep();
    int exp_lat[4] = '{5, 17, 1, 3};
    int lat[4];
    int c;
    logic [33:0] got[4];
    logic [33:0] e[4];
    logic [3:0] dn;
    logic [16:0] a, b;
    logic s;
    for (int i = 0; i < 600; i++) begin
      s = i[0];
      unique case ((i >> 1) % 6)
        0: a = 17'h10000;
        1: a = 17'h1FFFF;
        2: a = 17'h00080;
        default: a = 17'($urandom);
      endcase
      unique case ((i >> 3) % 5)
        0: b = 17'h10000;
        1: b = 17'h00000;
        2: b = 17'h000FF;
        default: b = 17'($urandom);
      endcase
      q0.push_back(ref17(a, b, s));
      q1.push_back(ref17(a, b, s));
      q2.push_back(ref17(a, b, s));
      q3.push_back({18'b0, ref8(a[7:0], b[7:0], s)});
      a17 = a;
      b17 = b;
      signed_op = s;
      start = 1'b1;
      lat = '{0, 0, 0, 0};
      c = 0;
      dn = '0;
      while (dn != 4'hF && c < 40) begin
        tick();
        c++;
        if (done0 && !dn[0]) lat[0] = c - 1;
        if (done1 && !dn[1]) lat[1] = c - 1;
        if (done2 && !dn[2]) lat[2] = c - 1;
        if (done3 && !dn[3]) lat[3] = c - 1;
        dn = dn | {done3, done2, done1, done0};
      end
      got = '{p0, p1, p2, {18'b0, p3}};
      e[0] = q0.pop_front();
      e[1] = q1.pop_front();
      e[2] = q2.pop_front();
      e[3] = q3.pop_front();
      for (int k = 0; k < 4; k++) begin
        vecs++;
        if (got[k] !== e[k]) begin
          errs++;
          $display("FAIL sweep_P u%0d a=%h b=%h s=%b: got %h want %h",
                   k, a, b, s, got[k], e[k]);
        end
        vecs++;
        if (lat[k] != exp_lat[k]) begin
          errs++;
          $display("FAIL sweep_lat u%0d: got %0d want %0d",
                   k, lat[k], exp_lat[k]);
        end
      end
      release_start();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_abort();
    test_reset_mid();
    test_handshake();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
